// File: rtl/pwm_cfg_pkg.sv
// rtl/pwm_cfg_pkg.sv - shared sizes, frame layout and FSM states for the PWM SPI config block
package pwm_cfg_pkg;

  localparam int NUM_CH      = 8;
  localparam int ADDR_W      = 3;
  localparam int DUTY_W      = 3;
  localparam int FRAME_W     = 8;
  localparam int FR_COMMIT   = 7;
  localparam int FR_WR       = 6;
  localparam int FR_ADDR_LSB = 3;
  localparam int FR_DUTY_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cfg_state_t;

  // Status byte shifted out on MISO at the start of every frame.
  function automatic logic [FRAME_W-1:0] status_byte(
    input logic              pending,
    input logic              err,
    input logic [ADDR_W-1:0] addr
  );
    return {pending, err, {(FRAME_W-2-ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/pwm_spi_config_ctrl_if.sv
// rtl/pwm_spi_config_ctrl_if.sv - SPI pin bundle between the chip I/O and the config controller
interface pwm_spi_config_ctrl_if;

  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synced level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/pwm_spi_config_ctrl.sv
// rtl/pwm_spi_config_ctrl.sv - SPI-slave frame decoder with shadowed duty registers committed at PWM period wrap
module pwm_spi_config_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pwm_spi_config_ctrl_if.slave     spi,
  input  logic                     period_start,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic                     commit_pending,
  output logic                     frame_err,
  output logic                     frame_done
);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_n_s, cs_rise_unused, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi.spi_sck),
    .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi.spi_cs_n),
    .dout(cs_n_s), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi.spi_mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  cfg_state_t         state;
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [2:0]         bit_cnt;
  logic               miso_q;
  logic [DUTY_W-1:0]  shadow [NUM_CH];
  logic [ADDR_W-1:0]  last_addr;

  logic               fr_commit, fr_wr;
  logic [ADDR_W-1:0]  fr_addr;
  logic [DUTY_W-1:0]  fr_duty;
  logic               in_done, do_commit, short_abort;
  logic               pending_nxt, err_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [FRAME_W-1:0] status_nxt;

  assign fr_commit   = rx_sr[FR_COMMIT];
  assign fr_wr       = rx_sr[FR_WR];
  assign fr_addr     = rx_sr[FR_ADDR_LSB +: ADDR_W];
  assign fr_duty     = rx_sr[FR_DUTY_LSB +: DUTY_W];
  assign in_done     = (state == DONE);
  assign do_commit   = period_start && commit_pending;
  assign short_abort = (state == SHIFT) && cs_n_s && (bit_cnt != 3'd0);

  // Period transfer is evaluated first so a same-cycle COMMIT re-arms pending.
  always_comb begin
    pending_nxt = commit_pending;
    if (do_commit)              pending_nxt = 1'b0;
    if (in_done && fr_commit)   pending_nxt = 1'b1;
    err_nxt = frame_err;
    if (short_abort)                      err_nxt = 1'b1;
    if (in_done && !fr_commit && !fr_wr)  err_nxt = 1'b0;
    addr_nxt = last_addr;
    if (in_done && fr_wr)       addr_nxt = fr_addr;
  end

  assign status_nxt   = status_byte(pending_nxt, err_nxt, addr_nxt);
  assign spi.spi_miso = miso_q & ~spi.spi_cs_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
      frame_err      <= 1'b0;
      last_addr      <= '0;
      duty           <= '0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else begin
      commit_pending <= pending_nxt;
      frame_err      <= err_nxt;
      last_addr      <= addr_nxt;
      if (do_commit) begin
        for (int k = 0; k < NUM_CH; k++) duty[k*DUTY_W +: DUTY_W] <= shadow[k];
      end
      if (in_done && fr_wr) shadow[fr_addr] <= fr_duty;
    end
  end

  // In DONE the full status is parked in tx_sr; the trailing sck fall of the
  // finished frame then presents its MSB for a back-to-back frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= 3'd0;
      miso_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          miso_q  <= 1'b0;
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state  <= SHIFT;
            miso_q <= status_nxt[FRAME_W-1];
            tx_sr  <= {status_nxt[FRAME_W-2:0], 1'b0};
          end
        end
        SHIFT: begin
          if (cs_n_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso_q  <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_sr   <= {rx_sr[FRAME_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
            if (sck_fall) begin
              miso_q <= tx_sr[FRAME_W-1];
              tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          bit_cnt <= 3'd0;
          tx_sr   <= status_nxt;
          if (cs_n_s) begin
            state  <= IDLE;
            miso_q <= 1'b0;
          end else begin
            state <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
